pv_inhibition_bank: RTL and testbench

Multi-channel PV+ basket-cell inhibition engine. It generalises the single-column, hard-wired PV+ feedback path into a parametrised bank of NCH channels. Each channel tracks the amplitude envelope of one L2/3 oscillator (x, y) with a leaky integrator and produces a thresholded, gain-scaled, saturated inhibitory current. The block sits between the cortical_column L2/3 outputs and their inhibitory inputs. All channels are processed by one time-multiplexed datapath on each clk_en update tick.

---
 rtl/pv_inhibition_bank_pkg.sv | 24 ++
 rtl/pv_env_lane.sv | 75 +++++++
 rtl/pv_inhibition_bank.sv | 133 +++++++++++++
 tb/tb_pv_inhibition_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pv_inhibition_bank_pkg.sv
// Shared fixed-point constants, FSM encoding and saturation helper for the
// PV+ inhibition bank; also used by cortical_column.
package pv_inhibition_bank_pkg;

  localparam int PV_WIDTH = 18;
  localparam int PV_FRAC  = 14;

  localparam longint ONE     = longint'(1) << PV_FRAC;
  localparam longint SAT_MAX = (longint'(1) << (PV_WIDTH - 1)) - 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SCAN    = 2'd1;
  localparam logic [1:0] ST_DRAIN   = 2'd2;
  localparam logic [1:0] ST_PUBLISH = 2'd3;

  // Clamp a wide intermediate into [lo, hi]; the callers keep all arithmetic
  // in 64 bits so nothing can wrap before it is clamped here.
  function automatic longint sat_clamp(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pv_env_lane.sv
// One envelope lane: amplitude estimate (stage A, registered) followed by the
// leaky-integrator envelope update and thresholded, gain-scaled inhibition.
module pv_env_lane
  import pv_inhibition_bank_pkg::*;
#(
  parameter int WIDTH    = PV_WIDTH,
  parameter int FRAC     = PV_FRAC,
  parameter int TAU_SLOW = 4,
  parameter int TAU_FAST = 2,
  parameter int THRESH   = 1638,
  parameter int INH_MAX  = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic signed [WIDTH-1:0] x,
  input  logic signed [WIDTH-1:0] y,
  input  logic        [WIDTH-1:0] env_in,
  input  logic signed [WIDTH-1:0] gain,
  input  logic                    fast,
  output logic        [WIDTH-1:0] env_next,
  output logic        [WIDTH-1:0] inh
);

  localparam longint SMAX = (longint'(1) << (WIDTH - 1)) - 1;
  localparam longint THR  = longint'(THRESH);
  localparam longint IMAX = longint'(INH_MAX);

  logic [WIDTH-1:0] amp_d;
  logic [WIDTH-1:0] amp_q;
  longint ax, ay, amp_hi, amp_lo;
  longint diff, step, env_n, gain_pos, prod;
  int tau;

  // Stage A: alpha-max-plus-beta-min amplitude; |most-negative| saturates
  // instead of wrapping back to a negative value.
  always_comb begin
    ax = longint'(x);
    ay = longint'(y);
    if (ax < 0) ax = -ax;
    if (ay < 0) ay = -ay;
    ax = sat_clamp(ax, 0, SMAX);
    ay = sat_clamp(ay, 0, SMAX);
    if (ax >= ay) begin
      amp_hi = ax;
      amp_lo = ay;
    end else begin
      amp_hi = ay;
      amp_lo = ax;
    end
    amp_d = WIDTH'(sat_clamp(amp_hi + (amp_lo >>> 1), 0, SMAX));
  end

  // Stage A register, loaded once per issued channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) amp_q <= '0;
    else if (load) amp_q <= amp_d;
  end

  // Stages B/C: move the envelope a 2^-tau fraction toward the amplitude,
  // then derive inhibition from the updated envelope in the same cycle.
  always_comb begin
    tau      = fast ? TAU_FAST : TAU_SLOW;
    diff     = longint'(amp_q) - longint'(env_in);
    step     = diff >>> tau;
    env_n    = sat_clamp(longint'(env_in) + step, 0, SMAX);
    gain_pos = longint'(gain);
    if (gain_pos < 0) gain_pos = 0;
    prod     = (env_n * gain_pos) >>> FRAC;
    env_next = WIDTH'(env_n);
    if (env_n < THR) inh = '0;
    else inh = WIDTH'(sat_clamp(prod, 0, IMAX));
  end

endmodule

// File: rtl/pv_inhibition_bank.sv
// Multi-channel PV+ inhibition bank: one time-multiplexed envelope lane walks
// all channels per update tick and publishes all outputs together at the end.
module pv_inhibition_bank
  import pv_inhibition_bank_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int FRAC     = 14,
  parameter int NCH      = 4,
  parameter int TAU_SLOW = 4,
  parameter int TAU_FAST = 2,
  parameter int THRESH   = 1638,
  parameter int INH_MAX  = 8192
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [NCH*WIDTH-1:0]    exc_x,
  input  logic [NCH*WIDTH-1:0]    exc_y,
  input  logic signed [WIDTH-1:0] gain,
  input  logic                    fast_mode,
  output logic [NCH*WIDTH-1:0]    inh_out,
  output logic [NCH*WIDTH-1:0]    env_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    drain_cnt;
  logic [NCH*WIDTH-1:0]    snap_x;
  logic [NCH*WIDTH-1:0]    snap_y;
  logic signed [WIDTH-1:0] snap_gain;
  logic                    snap_fast;
  logic                    a_valid;
  logic [CW-1:0]           a_idx;
  logic [WIDTH-1:0]        env_work [NCH];
  logic [WIDTH-1:0]        inh_work [NCH];
  logic signed [WIDTH-1:0] lane_x;
  logic signed [WIDTH-1:0] lane_y;
  logic [WIDTH-1:0]        lane_env;
  logic [WIDTH-1:0]        lane_inh;

  assign lane_x = snap_x[int'(cnt)*WIDTH +: WIDTH];
  assign lane_y = snap_y[int'(cnt)*WIDTH +: WIDTH];
  assign busy   = (state != ST_IDLE);

  pv_env_lane #(
    .WIDTH(WIDTH), .FRAC(FRAC), .TAU_SLOW(TAU_SLOW), .TAU_FAST(TAU_FAST),
    .THRESH(THRESH), .INH_MAX(INH_MAX)
  ) u_lane (
    .clk(clk),
    .rst(rst),
    .load(state == ST_SCAN),
    .x(lane_x),
    .y(lane_y),
    .env_in(env_work[a_idx]),
    .gain(snap_gain),
    .fast(snap_fast),
    .env_next(lane_env),
    .inh(lane_inh)
  );

  // Scan sequencer, pipeline write-back and output publish; the working
  // envelopes persist across scans while the outputs only move at PUBLISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      drain_cnt <= 1'b0;
      snap_x    <= '0;
      snap_y    <= '0;
      snap_gain <= '0;
      snap_fast <= 1'b0;
      a_valid   <= 1'b0;
      a_idx     <= '0;
      inh_out   <= '0;
      env_out   <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        env_work[i] <= '0;
        inh_work[i] <= '0;
      end
    end else begin
      done    <= 1'b0;
      a_valid <= (state == ST_SCAN);
      a_idx   <= cnt;
      if (a_valid) begin
        env_work[a_idx] <= lane_env;
        inh_work[a_idx] <= lane_inh;
      end
      if (clk_en && state != ST_IDLE) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (clk_en) begin
            snap_x    <= exc_x;
            snap_y    <= exc_y;
            snap_gain <= gain;
            snap_fast <= fast_mode;
            cnt       <= '0;
            state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (cnt == LAST) begin
            drain_cnt <= 1'b0;
            state     <= ST_DRAIN;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          for (int i = 0; i < NCH; i++) begin
            env_out[i*WIDTH +: WIDTH] <= env_work[i];
            inh_out[i*WIDTH +: WIDTH] <= inh_work[i];
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pv_inhibition_bank.sv
// Directed bench for pv_inhibition_bank with hand-computed expectations.
module tb_pv_inhibition_bank;

  localparam int WIDTH = 18;
  localparam int NCH   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic fast_mode = 1'b0;
  logic [NCH*WIDTH-1:0] exc_x = '0;
  logic [NCH*WIDTH-1:0] exc_y = '0;
  logic signed [WIDTH-1:0] gain = 18'sd16384;
  logic [NCH*WIDTH-1:0] inh_out;
  logic [NCH*WIDTH-1:0] env_out;
  logic busy, done, overrun;

  int tests = 0;
  int failed = 0;
  int lat;
  int e;
  int dones;
  int done_at;

  pv_inhibition_bank #(
    .WIDTH(WIDTH), .FRAC(14), .NCH(NCH), .TAU_SLOW(4), .TAU_FAST(2),
    .THRESH(1638), .INH_MAX(8192)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clk_en(clk_en),
    .exc_x(exc_x),
    .exc_y(exc_y),
    .gain(gain),
    .fast_mode(fast_mode),
    .inh_out(inh_out),
    .env_out(env_out),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hang guard.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int chan(input logic [NCH*WIDTH-1:0] bus, input int ch);
    return int'(bus[ch*WIDTH +: WIDTH]);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic setCh(input int ch, input int x, input int y);
    exc_x[ch*WIDTH +: WIDTH] = WIDTH'(x);
    exc_y[ch*WIDTH +: WIDTH] = WIDTH'(y);
  endtask

  // One update tick: pulse clk_en for edge E0 and wait (bounded) for done.
  task automatic applyStimulus(output int latency);
    latency = -1;
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    checkOutput("busy_in_scan", int'(busy), 1);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (done) begin
        latency = k;
        break;
      end
    end
    checkOutput("tick_latency", latency, NCH + 3);
    checkOutput("busy_after_publish", int'(busy), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_env_out_zero", int'(env_out == '0), 1);
    checkOutput("rst_inh_out_zero", int'(inh_out == '0), 1);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_overrun", int'(overrun), 0);
    checkOutput("rst_done", int'(done), 0);

    // All-zero tick
    applyStimulus(lat);
    checkOutput("zero_env_out", int'(env_out == '0), 1);
    checkOutput("zero_inh_out", int'(inh_out == '0), 1);

    // Amplitude approximation and most-negative saturation, fast mode
    setCh(2, -4000, 3000);
    setCh(3, -131072, 0);
    fast_mode = 1'b1;
    applyStimulus(lat);
    checkOutput("amp_env2", chan(env_out, 2), 1375);
    checkOutput("amp_inh2_below_thresh", chan(inh_out, 2), 0);
    checkOutput("sat_env3", chan(env_out, 3), 32767);
    checkOutput("sat_inh3_clamped", chan(inh_out, 3), 8192);
    checkOutput("amp_env0_idle", chan(env_out, 0), 0);

    // Mid-scan asynchronous reset
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_env_out_zero", int'(env_out == '0), 1);
    checkOutput("midrst_inh_out_zero", int'(inh_out == '0), 1);
    checkOutput("midrst_busy", int'(busy), 0);
    checkOutput("midrst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (done) dones++;
    end
    checkOutput("midrst_no_done", dones, 0);

    // Step on ch0, slow mode, unit gain; ch1..3 stay silent
    setCh(2, 0, 0);
    setCh(3, 0, 0);
    setCh(0, 8192, 0);
    fast_mode = 1'b0;
    gain = 18'sd16384;
    e = 0;
    applyStimulus(lat);
    e = e + ((8192 - e) >>> 4);
    checkOutput("step_env0_tick1", chan(env_out, 0), 512);
    checkOutput("step_inh0_tick1", chan(inh_out, 0), 0);
    checkOutput("step_env2_after_reset", chan(env_out, 2), 0);
    checkOutput("step_other_env_zero", int'(env_out[NCH*WIDTH-1:WIDTH] == '0), 1);
    for (int t = 2; t <= 32; t++) begin
      applyStimulus(lat);
      e = e + ((8192 - e) >>> 4);
    end
    checkOutput("step_env0_tick32", chan(env_out, 0), e);
    checkOutput("step_inh0_eq_env0", chan(inh_out, 0), e);
    checkOutput("step_other_inh_zero", int'(inh_out[NCH*WIDTH-1:WIDTH] == '0), 1);
    for (int t = 33; t <= 110; t++) begin
      applyStimulus(lat);
      e = e + ((8192 - e) >>> 4);
    end
    checkOutput("conv_env0", chan(env_out, 0), e);
    checkOutput("conv_env0_within_64", int'((8192 - chan(env_out, 0)) <= 64), 1);

    // Gain scaling and clamp on the converged envelope
    gain = 18'sd65536;
    applyStimulus(lat);
    e = e + ((8192 - e) >>> 4);
    checkOutput("gain4_inh0_clamp", chan(inh_out, 0), 8192);
    gain = 18'sd8192;
    applyStimulus(lat);
    e = e + ((8192 - e) >>> 4);
    checkOutput("gain_half_inh0", chan(inh_out, 0), (e * 8192) >>> 14);
    gain = -18'sd16384;
    applyStimulus(lat);
    e = e + ((8192 - e) >>> 4);
    checkOutput("gain_neg_inh0", chan(inh_out, 0), 0);
    checkOutput("gain_neg_env0", chan(env_out, 0), e);

    // Overrun: extra clk_en at E0+2 (SCAN) and E0+7 (PUBLISH)
    gain = 18'sd16384;
    dones = 0;
    done_at = -1;
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1 clk_en = 1'b0;
    checkOutput("ovr_clear_before", int'(overrun), 0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      clk_en = (k == 2 || k == 7);
      @(posedge clk);
      #1 clk_en = 1'b0;
      if (done) begin
        dones++;
        done_at = k;
      end
      if (k == 2) checkOutput("ovr_set_in_scan", int'(overrun), 1);
    end
    checkOutput("ovr_single_done", dones, 1);
    checkOutput("ovr_done_cycle", done_at, NCH + 3);
    checkOutput("ovr_sticky", int'(overrun), 1);
    checkOutput("ovr_no_second_scan", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
